data_bus_receive_os_detect: RTL and testbench

//  Receive-side counterpart of the lane-0 transmit path; sits between the lane-0 receive byte stream and the control FSM.

---
 rtl/usb4_lane_pkg.sv | 54 +++++
 rtl/prbs11_byte_gen.sv | 43 ++++
 rtl/data_bus_receive_os_detect.sv | 196 +++++++++++++++++++
 tb/tb_data_bus_receive_os_detect.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb4_lane_pkg.sv
// Shared lane-0 definitions: ordered-set codes, ordered-set patterns and PRBS11 constants.
// Used by both the receive detector and the transmit path.
package usb4_lane_pkg;

  typedef enum logic [3:0] {
    OS_SLOS1  = 4'd0,
    OS_SLOS2  = 4'd1,
    OS_G3_TS1 = 4'd2,
    OS_G3_TS2 = 4'd3,
    OS_G4_TS1 = 4'd4,
    OS_G4_TS2 = 4'd5,
    OS_G4_TS3 = 4'd6,
    OS_G4_TS4 = 4'd7,
    OS_DATA   = 4'd8
  } os_code_e;

  typedef enum logic [1:0] {
    RX_SEARCH   = 2'd0,
    RX_SLOS_CHK = 2'd1,
    RX_DATA     = 2'd2
  } rx_state_e;

  localparam logic [63:0] G3_TS1        = 64'h0101_0000_0000_64F2;
  localparam logic [63:0] G3_TS2        = 64'h0100_0000_0000_64F2;
  localparam logic [31:0] G4_TS1_HEAD   = 32'h7E02_D0F0;
  localparam logic [31:0] G4_TS2_HEAD   = 32'h7E04_B0F0;
  localparam logic [31:0] G4_TS3_HEAD   = 32'h7E06_90F0;
  localparam logic [15:0] G4_TS4_PREFIX = 16'h7E0F;

  localparam logic [10:0] PRBS11_SEED = 11'b100_0000_0000;

  // First eight PRBS11 output bits from a given state, first bit in bit 7.
  function automatic logic [7:0] prbs11_first_byte(input logic [10:0] seed);
    logic [10:0] p;
    logic [7:0]  b;
    p = seed;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[7-i] = p[0];
      p      = {p[9:0], p[10] ^ p[8]};
    end
    return b;
  endfunction

  localparam logic [7:0] SLOS1_FIRST = prbs11_first_byte(PRBS11_SEED);

  // TS4 header 7E 0F nn m0: counter n in 1..15 and check nibble m == 15-n.
  function automatic logic g4_ts4_match(input logic [31:0] w);
    return (w[31:16] == G4_TS4_PREFIX) && (w[15:12] == 4'd0) &&
           (w[11:8] != 4'd0) && (w[3:0] == 4'd0) &&
           (w[7:4] == (4'd15 - w[11:8]));
  endfunction

endpackage

// File: rtl/prbs11_byte_gen.sv
// PRBS11 generator producing eight bits per advance, first bit in bit 7.
// Shared by the lane-0 transmitter and the receive-side SLOS checker.
module prbs11_byte_gen
  import usb4_lane_pkg::*;
#(
  parameter logic [10:0] SEED = PRBS11_SEED
) (
  input  logic        fsm_clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_advance,
  output logic [7:0]  o_byte,
  output logic [10:0] o_next_state
);

  logic [10:0] r_state;
  logic [10:0] w_p;
  logic [7:0]  w_byte;

  always_comb begin
    w_p    = r_state;
    w_byte = '0;
    for (int i = 0; i < 8; i++) begin
      w_byte[7-i] = w_p[0];
      w_p         = {w_p[9:0], w_p[10] ^ w_p[8]};
    end
  end

  assign o_byte       = w_byte;
  assign o_next_state = w_p;

  // Load wins over advance so a restart never consumes a byte of sequence.
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_advance) begin
      r_state <= w_p;
    end
  end

endmodule

// File: rtl/data_bus_receive_os_detect.sv
// Lane-0 receive path: detects SLOS1/2, Gen3 TS1/2 and Gen4 TS1..TS4 ordered sets,
// or forwards transport bytes when the control FSM selects data mode.
module data_bus_receive_os_detect
  import usb4_lane_pkg::*;
#(
  parameter logic [10:0] SEED       = PRBS11_SEED,
  parameter int          SLOS_BYTES = 256
) (
  input  logic       fsm_clk,
  input  logic       rst,
  input  logic [7:0] lane_0_rx,
  input  logic       lane_0_rx_valid,
  input  logic       gen4_mode,
  input  logic       rx_data_en,
  output logic [3:0] os_code,
  output logic       os_valid,
  output logic [3:0] ts4_index,
  output logic [7:0] transport_layer_data_out,
  output logic       transport_data_valid
);

  localparam int             CNT_W      = $clog2(SLOS_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOS_BYTES);
  localparam logic [7:0]     FIRST_BYTE = prbs11_first_byte(SEED);

  rx_state_e        r_state, r_state_next;
  logic [63:0]      r_window, r_window_next;
  logic [CNT_W-1:0] r_count, r_count_next;
  logic             r_polarity, r_polarity_next;
  logic             r_os_valid, r_os_valid_next;
  os_code_e         r_os_code, r_os_code_next;
  logic [3:0]       r_ts4_index, r_ts4_index_next;
  logic [7:0]       r_tl_data, r_tl_data_next;
  logic             r_tl_valid, r_tl_valid_next;

  logic [63:0]      w_shifted;
  logic             w_ts_hit;
  os_code_e         w_ts_code;
  logic [7:0]       w_prbs_byte;
  logic [7:0]       w_prbs_expect;
  logic             w_prbs_load;
  logic             w_prbs_adv;
  logic [10:0]      w_unused_prbs_next;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_slos_entry;

  prbs11_byte_gen #(
    .SEED (SEED)
  ) u_prbs_chk (
    .fsm_clk      (fsm_clk),
    .rst          (rst),
    .i_load       (w_prbs_load),
    .i_advance    (w_prbs_adv),
    .o_byte       (w_prbs_byte),
    .o_next_state (w_unused_prbs_next)
  );

  assign w_shifted     = {r_window[55:0], lane_0_rx};
  assign w_prbs_expect = r_polarity ? ~w_prbs_byte : w_prbs_byte;
  assign w_count_inc   = r_count + CNT_W'(1);
  assign w_slos_entry  = (lane_0_rx == FIRST_BYTE) || (lane_0_rx == ~FIRST_BYTE);

  // Ordered-set decode on the window as it will look after this byte.
  always_comb begin
    w_ts_hit  = 1'b0;
    w_ts_code = OS_G4_TS1;
    if (gen4_mode) begin
      if (w_shifted[31:0] == G4_TS1_HEAD) begin
        w_ts_hit  = 1'b1;
        w_ts_code = OS_G4_TS1;
      end else if (w_shifted[31:0] == G4_TS2_HEAD) begin
        w_ts_hit  = 1'b1;
        w_ts_code = OS_G4_TS2;
      end else if (w_shifted[31:0] == G4_TS3_HEAD) begin
        w_ts_hit  = 1'b1;
        w_ts_code = OS_G4_TS3;
      end else if (g4_ts4_match(w_shifted[31:0])) begin
        w_ts_hit  = 1'b1;
        w_ts_code = OS_G4_TS4;
      end
    end else begin
      if (w_shifted == G3_TS1) begin
        w_ts_hit  = 1'b1;
        w_ts_code = OS_G3_TS1;
      end else if (w_shifted == G3_TS2) begin
        w_ts_hit  = 1'b1;
        w_ts_code = OS_G3_TS2;
      end
    end
  end

  always_comb begin
    r_state_next     = r_state;
    r_window_next    = r_window;
    r_count_next     = r_count;
    r_polarity_next  = r_polarity;
    r_os_valid_next  = 1'b0;
    r_os_code_next   = r_os_code;
    r_ts4_index_next = r_ts4_index;
    r_tl_data_next   = r_tl_data;
    r_tl_valid_next  = 1'b0;
    w_prbs_load      = 1'b0;
    w_prbs_adv       = 1'b0;

    if (rx_data_en) begin
      // Data mode overrides everything; keep the checker parked at the seed.
      r_state_next = RX_DATA;
      r_count_next = '0;
      w_prbs_load  = 1'b1;
      if ((r_state == RX_DATA) && lane_0_rx_valid) begin
        r_tl_data_next  = lane_0_rx;
        r_tl_valid_next = 1'b1;
      end
    end else begin
      case (r_state)
        RX_DATA: begin
          r_state_next  = RX_SEARCH;
          r_window_next = '0;
        end
        RX_SEARCH: begin
          if (lane_0_rx_valid) begin
            r_window_next = w_shifted;
            if (w_ts_hit) begin
              r_os_valid_next = 1'b1;
              r_os_code_next  = w_ts_code;
              r_window_next   = '0;
              if (w_ts_code == OS_G4_TS4) begin
                r_ts4_index_next = w_shifted[11:8];
              end
            end else if (w_slos_entry) begin
              r_polarity_next = (lane_0_rx != FIRST_BYTE);
              r_count_next    = CNT_W'(1);
              w_prbs_adv      = 1'b1;
              r_state_next    = RX_SLOS_CHK;
            end
          end
        end
        RX_SLOS_CHK: begin
          if (lane_0_rx_valid) begin
            if (lane_0_rx == w_prbs_expect) begin
              r_count_next = w_count_inc;
              w_prbs_adv   = 1'b1;
              if (w_count_inc == CNT_LAST) begin
                r_os_valid_next = 1'b1;
                r_os_code_next  = r_polarity ? OS_SLOS2 : OS_SLOS1;
                r_count_next    = '0;
                w_prbs_load     = 1'b1;
                r_state_next    = RX_SEARCH;
              end
            end else begin
              // The failing byte seeds the window but cannot restart SLOS itself.
              r_count_next  = '0;
              w_prbs_load   = 1'b1;
              r_window_next = {56'd0, lane_0_rx};
              r_state_next  = RX_SEARCH;
            end
          end
        end
        default: begin
          r_state_next = RX_SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RX_SEARCH;
      r_window    <= '0;
      r_count     <= '0;
      r_polarity  <= 1'b0;
      r_os_valid  <= 1'b0;
      r_os_code   <= OS_SLOS1;
      r_ts4_index <= '0;
      r_tl_data   <= '0;
      r_tl_valid  <= 1'b0;
    end else begin
      r_state     <= r_state_next;
      r_window    <= r_window_next;
      r_count     <= r_count_next;
      r_polarity  <= r_polarity_next;
      r_os_valid  <= r_os_valid_next;
      r_os_code   <= r_os_code_next;
      r_ts4_index <= r_ts4_index_next;
      r_tl_data   <= r_tl_data_next;
      r_tl_valid  <= r_tl_valid_next;
    end
  end

  assign os_code                  = r_os_code;
  assign os_valid                 = r_os_valid;
  assign ts4_index                = r_ts4_index;
  assign transport_layer_data_out = r_tl_data;
  assign transport_data_valid     = r_tl_valid;

endmodule

// File: tb/tb_data_bus_receive_os_detect.sv
// Bench for the lane-0 receive ordered-set detector: directed scenarios plus a
// randomized stream checked against a byte-level reference model.
module tb_data_bus_receive_os_detect;

  logic       fsm_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lane_0_rx = 8'h00;
  logic       lane_0_rx_valid = 1'b0;
  logic       gen4_mode = 1'b0;
  logic       rx_data_en = 1'b0;
  logic [3:0] os_code;
  logic       os_valid;
  logic [3:0] ts4_index;
  logic [7:0] transport_layer_data_out;
  logic       transport_data_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] slos_seq [256];

  // reference model state
  int         m_mode;      // 0 search, 1 slos check, 2 data
  logic [7:0] m_win [$];   // last eight bytes, oldest first
  int         m_idx;
  logic       m_pol;
  logic [3:0] m_ts4;
  logic [7:0] m_tl_data;
  logic       e_os_valid;
  logic [3:0] e_code;
  logic       e_tl_valid;

  data_bus_receive_os_detect dut (
    .fsm_clk                  (fsm_clk),
    .rst                      (rst),
    .lane_0_rx                (lane_0_rx),
    .lane_0_rx_valid          (lane_0_rx_valid),
    .gen4_mode                (gen4_mode),
    .rx_data_en               (rx_data_en),
    .os_code                  (os_code),
    .os_valid                 (os_valid),
    .ts4_index                (ts4_index),
    .transport_layer_data_out (transport_layer_data_out),
    .transport_data_valid     (transport_data_valid)
  );

  always #5 fsm_clk = ~fsm_clk;

  function automatic void build_slos();
    logic [10:0] p;
    p = 11'h400;
    for (int k = 0; k < 2048; k++) begin
      slos_seq[k/8][7-(k%8)] = p[0];
      p = {p[9:0], p[10] ^ p[8]};
    end
  endfunction

  function automatic void model_clear_window();
    m_win.delete();
    for (int i = 0; i < 8; i++) m_win.push_back(8'h00);
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_idx = 0; m_pol = 1'b0; m_ts4 = 4'd0; m_tl_data = 8'h00;
    model_clear_window();
  endfunction

  function automatic void model_step(input logic [7:0] b, input logic v, input logic g4, input logic den);
    logic [31:0] w4;
    logic [63:0] w8;
    int          n;
    logic        hit;
    logic [3:0]  code;
    logic [7:0]  want;
    e_os_valid = 1'b0;
    e_tl_valid = 1'b0;
    if (den) begin
      if (m_mode == 2 && v) begin
        e_tl_valid = 1'b1;
        m_tl_data  = b;
      end
      m_mode = 2;
      m_idx  = 0;
      return;
    end
    if (m_mode == 2) begin
      m_mode = 0;
      model_clear_window();
      return;
    end
    if (!v) return;
    if (m_mode == 0) begin
      m_win.push_back(b);
      void'(m_win.pop_front());
      w4 = {m_win[4], m_win[5], m_win[6], m_win[7]};
      w8 = {m_win[0], m_win[1], m_win[2], m_win[3], w4};
      n = int'(m_win[6]);
      hit = 1'b0; code = 4'd0;
      if (g4) begin
        if (w4 == 32'h7E02D0F0) begin hit = 1'b1; code = 4'd4; end
        else if (w4 == 32'h7E04B0F0) begin hit = 1'b1; code = 4'd5; end
        else if (w4 == 32'h7E0690F0) begin hit = 1'b1; code = 4'd6; end
        else if (m_win[4] == 8'h7E && m_win[5] == 8'h0F && n >= 1 && n <= 15 &&
                 int'(m_win[7]) == (15 - n) * 16) begin
          hit = 1'b1; code = 4'd7;
        end
      end else begin
        if (w8 == 64'h01010000000064F2) begin hit = 1'b1; code = 4'd2; end
        else if (w8 == 64'h01000000000064F2) begin hit = 1'b1; code = 4'd3; end
      end
      if (hit) begin
        e_os_valid = 1'b1;
        e_code     = code;
        if (code == 4'd7) m_ts4 = 4'(n);
        model_clear_window();
      end else if (b == slos_seq[0] || b == ~slos_seq[0]) begin
        m_pol  = (b != slos_seq[0]);
        m_idx  = 1;
        m_mode = 1;
      end
    end else begin
      want = m_pol ? ~slos_seq[m_idx] : slos_seq[m_idx];
      if (b == want) begin
        m_idx++;
        if (m_idx == 256) begin
          e_os_valid = 1'b1;
          e_code     = m_pol ? 4'd1 : 4'd0;
          m_mode     = 0;
          m_idx      = 0;
        end
      end else begin
        m_mode = 0;
        m_idx  = 0;
        model_clear_window();
        m_win[7] = b;
      end
    end
  endfunction

  task automatic drive(input logic [7:0] b, input logic v);
    lane_0_rx       = b;
    lane_0_rx_valid = v;
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #2;
    if (os_valid !== 1'b0 || os_code !== 4'd0 || ts4_index !== 4'd0 ||
        transport_layer_data_out !== 8'h00 || transport_data_valid !== 1'b0) begin
      $display("FAIL reset_outputs: got valid=%b code=%0d ts4=%0d data=%h dvalid=%b, want all 0",
               os_valid, os_code, ts4_index, transport_layer_data_out, transport_data_valid);
      n_errors++;
    end
    n_checks++;
    @(posedge fsm_clk); #1;
    rst = 1'b1;
    drive(8'h00, 1'b0);
    drive(8'h7E, 1'b0);
    if (os_valid !== 1'b0 || transport_data_valid !== 1'b0 || ts4_index !== 4'd0) begin
      $display("FAIL reset_idle: got valid=%b dvalid=%b ts4=%0d, want 0 0 0",
               os_valid, transport_data_valid, ts4_index);
      n_errors++;
    end
    n_checks++;
    $display("test_reset done");
  endtask

  task automatic test_g4_ts();
    logic [7:0] seq [12] = '{8'h7E, 8'h02, 8'hD0, 8'hF0, 8'h7E, 8'h04, 8'hB0, 8'hF0,
                             8'h7E, 8'h06, 8'h90, 8'hF0};
    logic [3:0] codes [3] = '{4'd4, 4'd5, 4'd6};
    gen4_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(seq[i], 1'b1);
      if (os_valid !== (i % 4 == 3)) begin
        $display("FAIL g4_ts_valid[%0d]: got %b want %b", i, os_valid, (i % 4 == 3));
        n_errors++;
      end
      n_checks++;
      if (i % 4 == 3) begin
        if (os_code !== codes[i/4]) begin
          $display("FAIL g4_ts_code[%0d]: got %0d want %0d", i, os_code, codes[i/4]);
          n_errors++;
        end
        n_checks++;
      end
    end
    drive(8'h00, 1'b0);
    if (os_valid !== 1'b0) begin
      $display("FAIL g4_ts_single_pulse: got %b want 0", os_valid);
      n_errors++;
    end
    n_checks++;
    $display("test_g4_ts done");
  endtask

  task automatic test_g4_ts4();
    logic [31:0] words [6] = '{32'h7E0F05A0, 32'h7E0F05B0, 32'h7E0F00F0, 32'h7E0F0F00,
                               32'h7E0F01E0, 32'h7E0F1EF0};
    logic        hits  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  idxs  [6] = '{4'd5, 4'd5, 4'd5, 4'd15, 4'd1, 4'd1};
    logic [31:0] w;
    gen4_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      w = words[t];
      for (int j = 0; j < 4; j++) drive(w[31-8*j -: 8], 1'b1);
      if (os_valid !== hits[t] || (hits[t] && os_code !== 4'd7)) begin
        $display("FAIL g4_ts4_hit[%h]: got valid=%b code=%0d want valid=%b code=7",
                 w, os_valid, os_code, hits[t]);
        n_errors++;
      end
      n_checks++;
      if (ts4_index !== idxs[t]) begin
        $display("FAIL g4_ts4_index[%h]: got %0d want %0d", w, ts4_index, idxs[t]);
        n_errors++;
      end
      n_checks++;
      $display("ts4 word %h valid=%b index=%0d", w, os_valid, ts4_index);
    end
  endtask

  task automatic test_g3_ts();
    logic [63:0] pats [3] = '{64'h01010000000064F2, 64'h01000000000064F2, 64'h00007E02D0F07E02};
    logic        hits [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0]  codes [3] = '{4'd2, 4'd3, 4'd0};
    logic [63:0] p;
    gen4_mode = 1'b0;
    for (int t = 0; t < 3; t++) begin
      p = pats[t];
      for (int j = 0; j < 8; j++) begin
        drive(p[63-8*j -: 8], 1'b1);
        if (j < 7) begin
          if (os_valid !== 1'b0) begin
            $display("FAIL g3_early[%0d.%0d]: got %b want 0", t, j, os_valid);
            n_errors++;
          end
          n_checks++;
          if (t == 0) drive(8'hF2, 1'b0);
        end
      end
      if (os_valid !== hits[t] || (hits[t] && os_code !== codes[t])) begin
        $display("FAIL g3_match[%h]: got valid=%b code=%0d want valid=%b code=%0d",
                 p, os_valid, os_code, hits[t], codes[t]);
        n_errors++;
      end
      n_checks++;
      $display("g3 pattern %h valid=%b code=%0d", p, os_valid, os_code);
    end
  endtask

  task automatic test_slos();
    logic [7:0] b;
    for (int t = 0; t < 3; t++) begin
      gen4_mode = 1'b0;
      for (int i = 0; i < 256; i++) begin
        b = (t == 1) ? ~slos_seq[i] : slos_seq[i];
        if (t == 2 && i == 99) b = b ^ 8'h01;
        drive(b, 1'b1);
        if (os_valid !== (t < 2 && i == 255)) begin
          $display("FAIL slos_valid[t%0d b%0d]: got %b want %b", t, i, os_valid, (t < 2 && i == 255));
          n_errors++;
        end
        n_checks++;
      end
      if (t < 2) begin
        if (os_code !== 4'(t)) begin
          $display("FAIL slos_code[t%0d]: got %0d want %0d", t, os_code, t);
          n_errors++;
        end
        n_checks++;
      end
      $display("slos stream %0d done", t);
    end
    gen4_mode = 1'b1;
    drive(8'h7E, 1'b1); drive(8'h02, 1'b1); drive(8'hD0, 1'b1); drive(8'hF0, 1'b1);
    if (os_valid !== 1'b1 || os_code !== 4'd4) begin
      $display("FAIL slos_back_to_search: got valid=%b code=%0d want 1 4", os_valid, os_code);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_data();
    logic [7:0] seq [6] = '{8'hAA, 8'h55, 8'h7E, 8'h02, 8'hD0, 8'hF0};
    gen4_mode  = 1'b1;
    rx_data_en = 1'b1;
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b1);
      if (transport_data_valid !== 1'b1 || transport_layer_data_out !== seq[i] || os_valid !== 1'b0) begin
        $display("FAIL data_fwd[%0d]: got dvalid=%b data=%h osv=%b want 1 %h 0",
                 i, transport_data_valid, transport_layer_data_out, os_valid, seq[i]);
        n_errors++;
      end
      n_checks++;
      $display("data byte %h forwarded as %h", seq[i], transport_layer_data_out);
    end
    drive(8'h11, 1'b0);
    if (transport_data_valid !== 1'b0) begin
      $display("FAIL data_idle: got dvalid=%b want 0", transport_data_valid);
      n_errors++;
    end
    n_checks++;
    rx_data_en = 1'b0;
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h7E, 1'b1); drive(8'h02, 1'b1); drive(8'hD0, 1'b1); drive(8'hF0, 1'b1);
    if (os_valid !== 1'b1 || os_code !== 4'd4 || transport_data_valid !== 1'b0) begin
      $display("FAIL data_exit_detect: got osv=%b code=%0d dvalid=%b want 1 4 0",
               os_valid, os_code, transport_data_valid);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_slos();
    int pulses;
    logic [3:0] pcode;
    gen4_mode = 1'b0;
    for (int i = 0; i < 200; i++) drive(slos_seq[i], 1'b1);
    rst = 1'b0;
    #1;
    if (os_valid !== 1'b0 || os_code !== 4'd0 || ts4_index !== 4'd0 ||
        transport_layer_data_out !== 8'h00 || transport_data_valid !== 1'b0) begin
      $display("FAIL midreset_outputs: got valid=%b code=%0d ts4=%0d data=%h dvalid=%b want all 0",
               os_valid, os_code, ts4_index, transport_layer_data_out, transport_data_valid);
      n_errors++;
    end
    n_checks++;
    @(posedge fsm_clk); @(posedge fsm_clk); #1;
    rst = 1'b1;
    pulses = 0;
    pcode  = 4'hF;
    for (int i = 0; i < 259; i++) begin
      drive(i < 256 ? slos_seq[i] : 8'h00, i < 256);
      if (os_valid === 1'b1) begin
        pulses++;
        pcode = os_code;
        if (i != 255) begin
          $display("FAIL midreset_pulse_pos: got pulse after byte %0d want after 255", i);
          n_errors++;
        end
        n_checks++;
      end
    end
    if (pulses != 1 || pcode !== 4'd0) begin
      $display("FAIL midreset_slos: got pulses=%0d code=%0d want 1 0", pulses, pcode);
      n_errors++;
    end
    n_checks++;
    $display("reset mid-SLOS then full SLOS1: pulses=%0d", pulses);
  endtask

  task automatic rand_cycle(input logic [7:0] b, input logic v);
    lane_0_rx       = b;
    lane_0_rx_valid = v;
    model_step(b, v, gen4_mode, rx_data_en);
    @(posedge fsm_clk);
    #1;
    if (os_valid !== e_os_valid) begin
      $display("FAIL rand_os_valid: byte=%h got %b want %b", b, os_valid, e_os_valid);
      n_errors++;
    end
    n_checks++;
    if (e_os_valid) begin
      if (os_code !== e_code) begin
        $display("FAIL rand_os_code: got %0d want %0d", os_code, e_code);
        n_errors++;
      end
      n_checks++;
    end
    if (ts4_index !== m_ts4) begin
      $display("FAIL rand_ts4_index: got %0d want %0d", ts4_index, m_ts4);
      n_errors++;
    end
    n_checks++;
    if (transport_data_valid !== e_tl_valid ||
        (e_tl_valid && transport_layer_data_out !== m_tl_data)) begin
      $display("FAIL rand_transport: got %b/%h want %b/%h",
               transport_data_valid, transport_layer_data_out, e_tl_valid, m_tl_data);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic rand_byte(input logic [7:0] b);
    if ($urandom_range(0, 3) == 0) rand_cycle(8'($urandom), 1'b0);
    rand_cycle(b, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] g4h [3] = '{32'h7E02D0F0, 32'h7E04B0F0, 32'h7E0690F0};
    logic [63:0] g3p [2] = '{64'h01010000000064F2, 64'h01000000000064F2};
    logic [31:0] w;
    logic [63:0] p;
    logic [3:0]  n, m;
    logic        pol;
    int          len, cor;
    rx_data_en = 1'b0;
    rst = 1'b0;
    @(posedge fsm_clk); #1;
    rst = 1'b1;
    model_reset();
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 3) == 0) gen4_mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: repeat ($urandom_range(1, 6)) rand_byte(8'($urandom));
        1: begin
          w = g4h[$urandom_range(0, 2)];
          for (int j = 0; j < 4; j++) rand_byte(w[31-8*j -: 8]);
        end
        2: begin
          n = 4'($urandom_range(0, 15));
          m = ($urandom_range(0, 2) != 0) ? 4'd15 - n : 4'($urandom);
          w = {16'h7E0F, 4'h0, n, m, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0};
          for (int j = 0; j < 4; j++) rand_byte(w[31-8*j -: 8]);
        end
        3: begin
          p = g3p[$urandom_range(0, 1)];
          for (int j = 0; j < 8; j++) rand_byte(p[63-8*j -: 8]);
        end
        4: begin
          pol = 1'($urandom_range(0, 1));
          len = ($urandom_range(0, 2) == 0) ? 256 : $urandom_range(1, 40);
          cor = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 255) : 999;
          for (int i = 0; i < len; i++)
            rand_byte((pol ? ~slos_seq[i] : slos_seq[i]) ^ ((i == cor) ? 8'h10 : 8'h00));
        end
        default: begin
          rx_data_en = 1'b1;
          rand_cycle(8'h00, 1'b0);
          rand_cycle(8'h00, 1'b0);
          repeat ($urandom_range(1, 5)) rand_byte(8'($urandom));
          rand_cycle(8'h00, 1'b0);
          rx_data_en = 1'b0;
          rand_cycle(8'h00, 1'b0);
          rand_cycle(8'h00, 1'b0);
        end
      endcase
    end
    $display("test_random done");
  endtask

  initial begin
    build_slos();
    model_reset();
    test_reset();
    test_g4_ts();
    test_g4_ts4();
    test_g3_ts();
    test_slos();
    test_data();
    test_reset_mid_slos();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
